mem_arbiter: RTL and testbench

Two-client request arbiter placed directly upstream of the external memory wrapper. It merges the instruction-fetch (I) and data (D) request streams onto the wrapper's single 70-bit packed port, which carries `get_enable`, `put_enable` and `put_request`. It records the issuing client of every accepted request in an in-order tag FIFO, then pulls responses and steers each one back to the client that issued it.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (I/D) request arbiter in front of the memory wrapper.
// Tracks the issuing client of each accepted request in an in-order tag FIFO and steers responses back.
module mem_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_req_valid,
  input  logic [67:0]      i_req_data,
  output logic             i_req_ready,
  input  logic             d_req_valid,
  input  logic [67:0]      d_req_data,
  output logic             d_req_ready,
  output logic             i_resp_valid,
  output logic [67:0]      i_resp_data,
  input  logic             i_resp_ready,
  output logic             d_resp_valid,
  output logic [67:0]      d_resp_data,
  input  logic             d_resp_ready,
  output logic [69:0]      mem_arg,
  input  logic [69:0]      mem_out,
  output logic [CNT_W-1:0] outstanding
);

  localparam int unsigned REQ_W = 68;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_d_q, last_d_d;

  logic             full;
  logic             empty;
  logic             any_req;
  logic             grant_d;
  logic             put_en;
  logic             get_en;
  logic             head_d;
  logic             acc;
  logic             pop;
  logic             put_ready;
  logic             get_ready;
  logic [REQ_W-1:0] get_response;
  logic [REQ_W-1:0] put_req;

  assign get_ready    = mem_out[69];
  assign put_ready    = mem_out[68];
  assign get_response = mem_out[REQ_W-1:0];

  // Arbitration, put/get handshakes and head-of-FIFO lookup
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    any_req = i_req_valid | d_req_valid;
    grant_d = d_req_valid & (~i_req_valid | ~last_d_q);
    put_en  = any_req & ~full;
    put_req = grant_d ? d_req_data : i_req_data;
    head_d  = tag_q[rd_ptr_q];
    get_en  = ~empty & (head_d ? d_resp_ready : i_resp_ready);
    acc     = put_en & put_ready;
    pop     = get_en & get_ready;
  end

  // Outputs are forced low while reset is asserted
  always_comb begin
    mem_arg      = RST_N ? {get_en, put_en, put_req} : '0;
    i_req_ready  = RST_N & acc & ~grant_d;
    d_req_ready  = RST_N & acc & grant_d;
    i_resp_valid = RST_N & pop & ~head_d;
    d_resp_valid = RST_N & pop & head_d;
    i_resp_data  = RST_N ? get_response : '0;
    d_resp_data  = RST_N ? get_response : '0;
    outstanding  = count_q;
  end

  // Tag FIFO, pointer and occupancy next-state
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d_d = last_d_q;
    count_d  = count_q;
    if (acc) begin
      tag_d[wr_ptr_q] = grant_d;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      last_d_d        = grant_d;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (acc && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !acc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // last_d resets high so I wins the first tie
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_d_q <= 1'b1;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_d_q <= last_d_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter; the bench acts as the in-order memory wrapper.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, d_req_valid;
  logic [67:0] i_req_data, d_req_data;
  logic        i_req_ready, d_req_ready;
  logic        i_resp_valid, d_resp_valid;
  logic [67:0] i_resp_data, d_resp_data;
  logic        i_resp_ready, d_resp_ready;
  logic [69:0] mem_arg;
  logic [69:0] mem_out;
  logic [2:0]  outstanding;

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  // in = {iv, dv, irr, drr, put_ready, get_ready}
  // ex = {i_req_ready, d_req_ready, put_enable, get_enable, i_resp_valid, d_resp_valid}
  typedef struct {
    logic [5:0] in_b;
    logic [5:0] ex_b;
    int         cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [68:0] sb[$];
  logic [67:0] mem_q[$];

  mem_arbiter dut (
    .CLK(clk), .RST_N(rst_n),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_ready(i_req_ready),
    .d_req_valid(d_req_valid), .d_req_data(d_req_data), .d_req_ready(d_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_ready(i_resp_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_ready(d_resp_ready),
    .mem_arg(mem_arg), .mem_out(mem_out), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [5:0] in_b, logic [5:0] ex_b, int cnt);
    vec_t v;
    v.in_b = in_b;
    v.ex_b = ex_b;
    v.cnt  = cnt;
    return v;
  endfunction

  task automatic chk(string name, int r, logic [69:0] got, logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, r, got, exp);
    end
  endtask

  // Applies one cycle of stimulus; addresses start at 0x100 (I) and 0x200 (D)
  task automatic drive(logic [5:0] b);
    i_req_valid  = b[5];
    d_req_valid  = b[4];
    i_resp_ready = b[3];
    d_resp_ready = b[2];
    i_req_data   = {4'h1, 32'h100 + 32'(seq) * 32'h10, 32'hA000_0000 | 32'(seq)};
    d_req_data   = {4'h2, 32'h200 + 32'(seq) * 32'h10, 32'hD000_0000 | 32'(seq)};
    mem_out      = {b[0], b[1], (mem_q.size() > 0) ? mem_q[0] : 68'h0};
    seq++;
  endtask

  // Response scoreboard plus the memory model's own put/get bookkeeping
  task automatic env(int r);
    logic [68:0] e;
    if (i_resp_valid || d_resp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected row %0d: got response with empty scoreboard, expected none", r);
      end else begin
        e = sb.pop_front();
        chk("resp_onehot", r, 70'(i_resp_valid & d_resp_valid), 70'(0));
        chk("resp_side", r, 70'(d_resp_valid), 70'(e[68]));
        chk("resp_data", r, 70'(d_resp_valid ? d_resp_data : i_resp_data), 70'(e[67:0]));
      end
    end
    if (mem_arg[68] && mem_out[68]) mem_q.push_back(mem_arg[67:0]);
    if (mem_arg[69] && mem_out[69] && mem_q.size() > 0) mem_q.delete(0);
  endtask

  task automatic run_row(vec_t v, int r);
    drive(v.in_b);
    if (v.ex_b[5]) sb.push_back({1'b0, i_req_data});
    if (v.ex_b[4]) sb.push_back({1'b1, d_req_data});
    @(negedge clk);
    chk("i_req_ready",  r, 70'(i_req_ready),  70'(v.ex_b[5]));
    chk("d_req_ready",  r, 70'(d_req_ready),  70'(v.ex_b[4]));
    chk("put_enable",   r, 70'(mem_arg[68]),  70'(v.ex_b[3]));
    chk("get_enable",   r, 70'(mem_arg[69]),  70'(v.ex_b[2]));
    chk("i_resp_valid", r, 70'(i_resp_valid), 70'(v.ex_b[1]));
    chk("d_resp_valid", r, 70'(d_resp_valid), 70'(v.ex_b[0]));
    chk("outstanding",  r, 70'(outstanding),  70'(v.cnt));
    env(r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Round-robin fill to full, then head-of-line block and drain
    tbl.push_back(mk(6'b110010, 6'b101000, 0));
    tbl.push_back(mk(6'b110010, 6'b011000, 1));
    tbl.push_back(mk(6'b110010, 6'b101000, 2));
    tbl.push_back(mk(6'b110010, 6'b011000, 3));
    tbl.push_back(mk(6'b110010, 6'b000000, 4));
    tbl.push_back(mk(6'b000111, 6'b000000, 4));
    tbl.push_back(mk(6'b001111, 6'b000110, 4));
    tbl.push_back(mk(6'b001111, 6'b000101, 3));
    // Refill, then pop-while-full blocks the accept for one cycle
    tbl.push_back(mk(6'b100010, 6'b101000, 2));
    tbl.push_back(mk(6'b010010, 6'b011000, 3));
    tbl.push_back(mk(6'b101111, 6'b000110, 4));
    tbl.push_back(mk(6'b100010, 6'b101000, 3));
    tbl.push_back(mk(6'b001111, 6'b000101, 4));
    tbl.push_back(mk(6'b001111, 6'b000110, 3));
    tbl.push_back(mk(6'b001111, 6'b000101, 2));
    tbl.push_back(mk(6'b001111, 6'b000110, 1));
    tbl.push_back(mk(6'b001111, 6'b000000, 0));
    // Ten D request/response pairs wrap both pointers
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk(6'b010111, 6'b011000, 0));
      tbl.push_back(mk(6'b001111, 6'b000101, 1));
    end
    // Tie after D grants goes to I; put_enable holds with put_ready low
    tbl.push_back(mk(6'b110010, 6'b101000, 0));
    tbl.push_back(mk(6'b110000, 6'b001000, 1));
    tbl.push_back(mk(6'b001011, 6'b000110, 1));

    rst_n = 1'b0;
    drive(6'b111111);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_arg",      -1, mem_arg,              70'(0));
    chk("rst_outstanding",  -1, 70'(outstanding),     70'(0));
    chk("rst_i_req_ready",  -1, 70'(i_req_ready),     70'(0));
    chk("rst_d_req_ready",  -1, 70'(d_req_ready),     70'(0));
    chk("rst_resp_valid",   -1, 70'(i_resp_valid | d_resp_valid), 70'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[r]) run_row(tbl[r], r);

    // Reset mid-operation discards the outstanding tag
    drive(6'b100010);
    @(negedge clk);
    chk("mid_i_req_ready", -2, 70'(i_req_ready), 70'(1));
    env(-2);
    @(posedge clk);
    #1;
    chk("mid_outstanding", -2, 70'(outstanding), 70'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outstanding", -2, 70'(outstanding), 70'(0));
    chk("mid_rst_mem_arg",     -2, mem_arg,          70'(0));
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(6'b001111);
    @(negedge clk);
    chk("post_rst_get_enable",  -3, 70'(mem_arg[69]),  70'(0));
    chk("post_rst_resp_valid",  -3, 70'(i_resp_valid | d_resp_valid), 70'(0));
    chk("post_rst_outstanding", -3, 70'(outstanding),  70'(0));
    env(-3);
    @(posedge clk);
    #1;

    chk("sb_drained",  -4, 70'(sb.size()),    70'(0));
    chk("mem_drained", -4, 70'(mem_q.size()), 70'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
